// File: rtl/spi_flash_fetch.sv
// spi_flash_fetch
//   Responder for the core's instruction fetch port. Serves 32-bit words from
//   an external SPI NOR flash using the serial READ command (SPI mode 0) and
//   keeps a one-word buffer so a re-fetch of the last word completes in one
//   cycle.
//
// Ports
//   clk          system clock
//   rstn         asynchronous active-low reset
//   instr_req    fetch request level, held by the core until instr_valid
//   instr_addr   byte address of the requested word (bits [1:0] ignored)
//   instr        fetched word, updated together with instr_valid
//   instr_valid  one-cycle pulse: instr holds the word for instr_addr
//   spi_sck      flash serial clock, idles low
//   spi_csn      flash chip select, active low
//   spi_mosi     command/address to the flash, MSB first
//   spi_miso     data from the flash
//   state_dbg    current FSM state (0 idle, 1 shift, 2 done, 3 gap)
//
// Handshake: instr_req is a level the core holds until it sees instr_valid.
// instr_valid is a single-cycle pulse and is never high two cycles in a row,
// so a request still held during the pulse cycle is not served twice.
module spi_flash_fetch #(
    parameter int         N        = 32,
    parameter int         CLK_DIV  = 1,
    parameter int         GAP      = 2,
    parameter logic [7:0] READ_CMD = 8'h03
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         instr_req,
    input  logic [N-1:0] instr_addr,
    output logic [N-1:0] instr,
    output logic         instr_valid,
    output logic         spi_sck,
    output logic         spi_csn,
    output logic         spi_mosi,
    input  logic         spi_miso,
    output logic [1:0]   state_dbg
);

    localparam int DIV_W = (2 * CLK_DIV > 1) ? $clog2(2 * CLK_DIV) : 1;
    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [DIV_W-1:0] RISE_AT  = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] FALL_AT  = DIV_W'(2 * CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    state_t           state, state_d;
    logic [DIV_W-1:0] div_cnt, div_cnt_d;
    logic [5:0]       bit_cnt, bit_cnt_d;
    logic [GAP_W-1:0] gap_cnt, gap_cnt_d;
    logic [31:0]      tx_sr, tx_sr_d;
    logic [31:0]      rx_sr, rx_sr_d;
    logic [N-1:2]     addr_q, addr_q_d;
    logic [N-1:0]     buf_word, buf_word_d;
    logic [N-1:2]     buf_tag, buf_tag_d;
    logic             buf_valid, buf_valid_d;
    logic [N-1:0]     instr_d;
    logic             instr_valid_d;
    logic             sck_d, csn_d, mosi_d;
    logic             hit;
    logic [N-1:0]     rx_word;
    logic             unused_addr_lsb;

    assign unused_addr_lsb = ^instr_addr[1:0];
    assign hit             = buf_valid && (buf_tag == instr_addr[N-1:2]);
    // Bytes arrive b0 first and end up in the top byte of rx_sr; the core
    // wants little-endian {b3,b2,b1,b0}.
    assign rx_word   = N'({rx_sr[7:0], rx_sr[15:8], rx_sr[23:16], rx_sr[31:24]});
    assign state_dbg = state;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= S_IDLE;
            div_cnt     <= '0;
            bit_cnt     <= '0;
            gap_cnt     <= '0;
            tx_sr       <= '0;
            rx_sr       <= '0;
            addr_q      <= '0;
            buf_word    <= '0;
            buf_tag     <= '0;
            buf_valid   <= 1'b0;
            instr       <= '0;
            instr_valid <= 1'b0;
            spi_sck     <= 1'b0;
            spi_csn     <= 1'b1;
            spi_mosi    <= 1'b0;
        end else begin
            state       <= state_d;
            div_cnt     <= div_cnt_d;
            bit_cnt     <= bit_cnt_d;
            gap_cnt     <= gap_cnt_d;
            tx_sr       <= tx_sr_d;
            rx_sr       <= rx_sr_d;
            addr_q      <= addr_q_d;
            buf_word    <= buf_word_d;
            buf_tag     <= buf_tag_d;
            buf_valid   <= buf_valid_d;
            instr       <= instr_d;
            instr_valid <= instr_valid_d;
            spi_sck     <= sck_d;
            spi_csn     <= csn_d;
            spi_mosi    <= mosi_d;
        end
    end

    always_comb begin
        state_d       = state;
        div_cnt_d     = div_cnt;
        bit_cnt_d     = bit_cnt;
        gap_cnt_d     = gap_cnt;
        tx_sr_d       = tx_sr;
        rx_sr_d       = rx_sr;
        addr_q_d      = addr_q;
        buf_word_d    = buf_word;
        buf_tag_d     = buf_tag;
        buf_valid_d   = buf_valid;
        instr_d       = instr;
        instr_valid_d = 1'b0;
        sck_d         = spi_sck;
        csn_d         = spi_csn;
        mosi_d        = spi_mosi;

        case (state)
            S_IDLE: begin
                // While the pulse is out the core still holds its request;
                // skip that cycle so the same fetch is not answered twice.
                if (instr_req && !instr_valid) begin
                    if (hit) begin
                        instr_d       = buf_word;
                        instr_valid_d = 1'b1;
                    end else begin
                        addr_q_d  = instr_addr[N-1:2];
                        // Command and address leave MSB first; zeros shift in
                        // behind them so mosi is low for the data phase.
                        tx_sr_d   = {READ_CMD, instr_addr[23:2], 2'b00};
                        mosi_d    = READ_CMD[7];
                        csn_d     = 1'b0;
                        sck_d     = 1'b0;
                        div_cnt_d = '0;
                        bit_cnt_d = '0;
                        state_d   = S_SHIFT;
                    end
                end
            end

            S_SHIFT: begin
                div_cnt_d = div_cnt + 1'b1;
                if (div_cnt == RISE_AT) begin
                    sck_d = 1'b1;
                    // Bits 32..63 are the data phase.
                    if (bit_cnt[5]) begin
                        rx_sr_d = {rx_sr[30:0], spi_miso};
                    end
                end
                if (div_cnt == FALL_AT) begin
                    sck_d     = 1'b0;
                    div_cnt_d = '0;
                    tx_sr_d   = {tx_sr[30:0], 1'b0};
                    mosi_d    = tx_sr[30];
                    bit_cnt_d = bit_cnt + 6'd1;
                    if (bit_cnt == 6'd63) begin
                        state_d = S_DONE;
                    end
                end
            end

            S_DONE: begin
                csn_d       = 1'b1;
                sck_d       = 1'b0;
                mosi_d      = 1'b0;
                buf_word_d  = rx_word;
                buf_tag_d   = addr_q;
                buf_valid_d = 1'b1;
                // The core may have moved on mid-frame; only answer if it
                // still wants this word, otherwise just keep it buffered.
                if (instr_req && (instr_addr[N-1:2] == addr_q)) begin
                    instr_d       = rx_word;
                    instr_valid_d = 1'b1;
                end
                gap_cnt_d = '0;
                state_d   = S_GAP;
            end

            S_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt + 1'b1;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_spi_flash_fetch.sv
module tb_spi_flash_fetch;

  localparam int GAP = 2;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rstn = 1'b0;

  // instance 0: CLK_DIV=1, instance 1: CLK_DIV=3
  logic        req   [2] = '{1'b0, 1'b0};
  logic [31:0] addr  [2] = '{32'h0, 32'h0};
  logic [31:0] instr [2];
  logic        valid [2];
  logic        sck   [2];
  logic        csn   [2];
  logic        mosi  [2];
  logic        miso  [2] = '{1'b0, 1'b0};
  logic [1:0]  dbg   [2];

  spi_flash_fetch #(.N(32), .CLK_DIV(1), .GAP(GAP), .READ_CMD(8'h03)) u_dut0 (
    .clk(clk), .rstn(rstn), .instr_req(req[0]), .instr_addr(addr[0]),
    .instr(instr[0]), .instr_valid(valid[0]), .spi_sck(sck[0]), .spi_csn(csn[0]),
    .spi_mosi(mosi[0]), .spi_miso(miso[0]), .state_dbg(dbg[0])
  );

  spi_flash_fetch #(.N(32), .CLK_DIV(3), .GAP(GAP), .READ_CMD(8'h03)) u_dut1 (
    .clk(clk), .rstn(rstn), .instr_req(req[1]), .instr_addr(addr[1]),
    .instr(instr[1]), .instr_valid(valid[1]), .spi_sck(sck[1]), .spi_csn(csn[1]),
    .spi_mosi(mosi[1]), .spi_miso(miso[1]), .state_dbg(dbg[1])
  );

  // flash contents (low 4 KB is enough for every address used)
  logic [7:0] mem [0:4095];

  // behavioural SPI NOR flash, one per instance
  int          rx_cnt     [2] = '{0, 0};
  int          frames     [2] = '{0, 0};
  int          sck_rises  [2] = '{0, 0};
  logic [31:0] sr         [2] = '{32'h0, 32'h0};
  logic [7:0]  last_cmd   [2] = '{8'h0, 8'h0};
  logic [23:0] last_faddr [2] = '{24'h0, 24'h0};
  logic        p_csn      [2] = '{1'b1, 1'b1};
  logic        p_sck      [2] = '{1'b0, 1'b0};

  // chip-select high-time monitor
  int hi_cnt  [2] = '{0, 0};
  int min_gap [2] = '{1000000, 1000000};
  bit started [2] = '{1'b0, 1'b0};

  for (genvar g = 0; g < 2; g++) begin : g_flash
    always @(csn[g] or sck[g]) begin : model
      int d;
      logic [11:0] ba;
      if (sck[g] === 1'b1 && p_sck[g] === 1'b0) sck_rises[g]++;
      if (csn[g] !== p_csn[g]) begin
        rx_cnt[g] = 0;
        sr[g] = '0;
      end else if (csn[g] === 1'b0) begin
        if (sck[g] === 1'b1 && p_sck[g] === 1'b0) begin
          if (rx_cnt[g] < 32) sr[g] = {sr[g][30:0], mosi[g]};
          rx_cnt[g]++;
          if (rx_cnt[g] == 32) begin
            frames[g]++;
            last_cmd[g] = sr[g][31:24];
            last_faddr[g] = sr[g][23:0];
          end
        end else if (sck[g] === 1'b0 && p_sck[g] === 1'b1 && rx_cnt[g] >= 32 && rx_cnt[g] < 64) begin
          d = rx_cnt[g] - 32;
          ba = last_faddr[g][11:0] + 12'(d / 8);
          miso[g] = mem[ba][7 - (d % 8)];
        end
      end
      p_csn[g] = csn[g];
      p_sck[g] = sck[g];
    end

    always @(negedge clk) begin
      if (csn[g] === 1'b1) begin
        hi_cnt[g]++;
      end else begin
        if (hi_cnt[g] > 0) begin
          if (started[g] && hi_cnt[g] < min_gap[g]) min_gap[g] = hi_cnt[g];
          started[g] = 1'b1;
        end
        hi_cnt[g] = 0;
      end
    end
  end

  // scoreboard / reference model
  int n_checks = 0;
  int n_fail = 0;
  logic        mdl_valid [2] = '{1'b0, 1'b0};
  logic [29:0] mdl_tag   [2] = '{30'h0, 30'h0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int div_of(input int g);
    return (g == 0) ? 1 : 3;
  endfunction

  function automatic logic [31:0] mdl_word(input logic [31:0] a);
    logic [11:0] b;
    b = {a[11:2], 2'b00};
    return {mem[b + 12'd3], mem[b + 12'd2], mem[b + 12'd1], mem[b]};
  endfunction

  function automatic int mdl_lat(input int g, input logic [31:0] a);
    if (mdl_valid[g] && mdl_tag[g] == a[31:2]) return 1;
    return 2 + 128 * div_of(g);
  endfunction

  // driver: raise a request, wait for the pulse (bounded), drop it
  task automatic do_req(input int g, input logic [31:0] a, output logic [31:0] w, output int lat);
    int lim;
    lim = 2 + 128 * div_of(g) + 50;
    w = '0;
    lat = -1;
    addr[g] = a;
    req[g] = 1'b1;
    for (int c = 1; c <= lim; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (valid[g]) begin
        lat = c;
        w = instr[g];
        break;
      end
    end
    req[g] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("no_double_valid", 32'(valid[g]), 32'h0);
    chk("instr_hold", instr[g], w);
    repeat (GAP + 2) @(negedge clk);
  endtask

  task automatic check_req(input int g, input logic [31:0] a, input logic [31:0] exp_w, input int exp_lat);
    int f0, s0, lat;
    logic [31:0] w;
    f0 = frames[g];
    s0 = sck_rises[g];
    do_req(g, a, w, lat);
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("word", w, exp_w);
    if (exp_lat == 1) begin
      chk("hit_no_frame", 32'(frames[g]), 32'(f0));
      chk("hit_no_sck", 32'(sck_rises[g]), 32'(s0));
    end else begin
      chk("miss_one_frame", 32'(frames[g]), 32'(f0 + 1));
      chk("cmd", 32'(last_cmd[g]), 32'h03);
      chk("frame_addr", 32'(last_faddr[g]), 32'({a[23:2], 2'b00}));
    end
    mdl_valid[g] = 1'b1;
    mdl_tag[g] = a[31:2];
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] word;
    int          lat;
  } vec_t;

  vec_t tbl [7];

  initial begin
    int lat;
    logic [31:0] w, a;
    int f0;

    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    mem[12'h100] = 8'h13; mem[12'h101] = 8'h05; mem[12'h102] = 8'h10; mem[12'h103] = 8'h00;
    mem[12'h104] = 8'h93; mem[12'h105] = 8'h05; mem[12'h106] = 8'h20; mem[12'h107] = 8'h00;

    tbl[0] = '{32'h0000_0100, 32'h0010_0513, 130};
    tbl[1] = '{32'h0000_0100, 32'h0010_0513, 1};
    tbl[2] = '{32'h0000_0104, 32'h0020_0593, 130};
    tbl[3] = '{32'h0000_0102, 32'h0010_0513, 130};
    tbl[4] = '{32'h0000_0102, 32'h0010_0513, 1};
    tbl[5] = '{32'h0100_0100, 32'h0010_0513, 130};
    tbl[6] = '{32'h0100_0103, 32'h0010_0513, 1};

    // reset state
    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk("rst_csn", 32'(csn[g]), 32'h1);
      chk("rst_sck", 32'(sck[g]), 32'h0);
      chk("rst_mosi", 32'(mosi[g]), 32'h0);
      chk("rst_valid", 32'(valid[g]), 32'h0);
      chk("rst_instr", instr[g], 32'h0);
    end
    rstn = 1'b1;
    repeat (3) @(negedge clk);

    // directed table: miss, hit, word alignment, tag includes upper bits
    for (int i = 0; i < 7; i++) check_req(0, tbl[i].addr, tbl[i].word, tbl[i].lat);

    // address changes mid-frame: no pulse for 0x100, new frame for 0x200
    f0 = frames[0];
    addr[0] = 32'h0000_0100;
    req[0] = 1'b1;
    lat = -1;
    w = '0;
    for (int c = 1; c <= 400; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (c == 25) addr[0] = 32'h0000_0200;
      if (valid[0]) begin
        lat = c;
        w = instr[0];
        break;
      end
    end
    req[0] = 1'b0;
    repeat (GAP + 3) @(negedge clk);
    chk("midframe_latency", 32'(lat), 32'(2 * 130 + GAP));
    chk("midframe_word", w, mdl_word(32'h200));
    chk("midframe_frames", 32'(frames[0]), 32'(f0 + 2));
    chk("midframe_faddr", 32'(last_faddr[0]), 32'h200);
    mdl_tag[0] = 30'(32'h200 >> 2);
    check_req(0, 32'h200, mdl_word(32'h200), mdl_lat(0, 32'h200));
    check_req(0, 32'h100, mdl_word(32'h100), mdl_lat(0, 32'h100));

    // reset in the middle of bit 40
    addr[0] = 32'h0000_0300;
    req[0] = 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (rx_cnt[0] >= 40) break;
    end
    chk("reached_bit40", 32'(rx_cnt[0] >= 40), 32'h1);
    rstn = 1'b0;
    #1;
    chk("abort_csn", 32'(csn[0]), 32'h1);
    chk("abort_sck", 32'(sck[0]), 32'h0);
    chk("abort_valid", 32'(valid[0]), 32'h0);
    chk("abort_instr", instr[0], 32'h0);
    req[0] = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    mdl_valid[0] = 1'b0;
    mdl_valid[1] = 1'b0;
    check_req(0, 32'h100, mdl_word(32'h100), mdl_lat(0, 32'h100));

    // randomized requests against the model
    for (int i = 0; i < 24; i++) begin
      a = {($urandom_range(0, 3) == 0) ? 8'h01 : 8'h00, 12'h000,
           10'($urandom_range(32'h40, 32'h43)), 2'($urandom_range(0, 3))};
      check_req(0, a, mdl_word(a), mdl_lat(0, a));
    end

    // slower SCK instance
    check_req(1, 32'h100, 32'h0010_0513, 386);
    check_req(1, 32'h100, 32'h0010_0513, 1);
    for (int i = 0; i < 3; i++) begin
      a = {20'h0, 10'($urandom_range(32'h40, 32'h60)), 2'b00};
      check_req(1, a, mdl_word(a), mdl_lat(1, a));
    end

    chk("csn_gap0", 32'(min_gap[0] >= GAP), 32'h1);
    chk("csn_gap1", 32'(min_gap[1] >= GAP), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
